// File: rtl/imem_pf_pkg.sv
// Shared types and constants for the instruction-memory prefetch buffer.
package imem_pf_pkg;

  localparam int XLEN       = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } pf_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// In-order word FIFO with push, pop and flush; exposes fill count and head word.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Word storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign count     = count_q;
  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Sequential instruction prefetcher between the i-cache refill port and the
// instruction memory bus.
//
//   state  | meaning
//   IDLE   | no stream; fetch pointer invalid, nothing is issued
//   STREAM | fa is the next word address to request on the bus
module imem_prefetch_buffer
  import imem_pf_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_DataReq,
  input  logic [XLEN-1:0] i_Addr,
  output logic [XLEN-1:0] o_Instr,
  output logic            o_MemReady,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] STEP     = XLEN'(WORD_BYTES);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(WORD_BYTES - 1);

  pf_state_e       state_q, state_n;
  logic [XLEN-1:0] fa_q, fa_n;
  logic [XLEN-1:0] head_addr_q, head_addr_n;
  logic [CW-1:0]   outstanding_q, outstanding_n;
  logic [CW-1:0]   discard_q, discard_n;
  logic            req_q, req_n;
  logic [XLEN-1:0] req_addr_q, req_addr_n;
  logic            req_drop_q, req_drop_n;
  logic            ready_q, ready_n;
  logic [XLEN-1:0] instr_q, instr_n;

  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] fifo_head;
  logic            fifo_push, fifo_pop, fifo_flush;

  logic [XLEN-1:0] addr_w;
  logic [CW-1:0]   live_total;
  logic [XLEN-1:0] oldest_addr;
  logic [CW:0]     fill_sum;
  logic            eval, fifo_empty, hit, pending, miss;
  logic            gnt_ev, rv_ev, drop_rv, can_issue;

  assign addr_w     = i_Addr & ~LOW_MASK;
  assign fifo_empty = (fifo_count == '0);
  assign eval       = i_DataReq && !ready_q;
  assign hit        = eval && !fifo_empty && (head_addr_q == addr_w);

  // Responses still owed to the live stream (discards and a doomed held
  // request excluded); fa has already moved past all of them.
  assign live_total  = outstanding_q - discard_q + CW'(req_q && !req_drop_q);
  assign oldest_addr = fa_q - XLEN'(live_total) * STEP;
  assign pending     = fifo_empty && (state_q == STREAM) && (oldest_addr == addr_w);
  assign miss        = eval && !hit && !pending;

  assign gnt_ev  = req_q && i_mem_gnt;
  assign rv_ev   = i_mem_rvalid && (outstanding_q != '0);
  assign drop_rv = rv_ev && ((discard_q != '0) || miss);

  // Reserved space counts words in flight too, so a push never meets a full FIFO.
  assign fill_sum  = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign can_issue = (state_q == STREAM) && !req_q &&
                     (fill_sum < (CW+1)'(DEPTH)) && (outstanding_q < CW'(MAX_OUT));

  // Next-state and datapath decisions for hit, miss, issue and response.
  always_comb begin
    state_n       = state_q;
    fa_n          = fa_q;
    head_addr_n   = head_addr_q;
    outstanding_n = outstanding_q + CW'(gnt_ev) - CW'(rv_ev);
    discard_n     = discard_q;
    req_n         = req_q;
    req_addr_n    = req_addr_q;
    req_drop_n    = req_drop_q;
    ready_n       = 1'b0;
    instr_n       = '0;
    fifo_push     = rv_ev && !drop_rv;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;

    if (hit) begin
      ready_n     = 1'b1;
      instr_n     = fifo_head;
      fifo_pop    = 1'b1;
      head_addr_n = head_addr_q + STEP;
    end

    if (gnt_ev) begin
      req_n      = 1'b0;
      req_drop_n = 1'b0;
    end

    if (miss) begin
      // Everything still on the bus belongs to the old stream.
      fifo_flush  = 1'b1;
      fifo_push   = 1'b0;
      discard_n   = outstanding_n;
      if (req_q && !gnt_ev) req_drop_n = 1'b1;
      head_addr_n = addr_w;
      fa_n        = addr_w;
      state_n     = STREAM;
    end else begin
      discard_n = discard_q - CW'(rv_ev && (discard_q != '0))
                            + CW'(gnt_ev && req_drop_q);
      if (can_issue) begin
        req_n      = 1'b1;
        req_addr_n = fa_q;
        fa_n       = fa_q + STEP;
      end
    end
  end

  // State register and all sequential bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= IDLE;
      fa_q          <= '0;
      head_addr_q   <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      req_q         <= 1'b0;
      req_addr_q    <= '0;
      req_drop_q    <= 1'b0;
      ready_q       <= 1'b0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_n;
      fa_q          <= fa_n;
      head_addr_q   <= head_addr_n;
      outstanding_q <= outstanding_n;
      discard_q     <= discard_n;
      req_q         <= req_n;
      req_addr_q    <= req_addr_n;
      req_drop_q    <= req_drop_n;
      ready_q       <= ready_n;
      instr_q       <= instr_n;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .push      (fifo_push),
    .push_data (i_mem_rdata),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .head_data (fifo_head)
  );

  assign o_MemReady = ready_q;
  assign o_Instr    = instr_q;
  assign o_mem_req  = req_q;
  assign o_mem_addr = req_addr_q;

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Bench for imem_prefetch_buffer: a memory agent with configurable grant and
// latency, a cache-side requester, and a per-cycle checker against the
// behavioural rules (data = memory image at the requested word, sequential
// bus addresses, held requests, bounded outstanding count).
module tb_imem_prefetch_buffer;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_DataReq = 1'b0;
  logic [31:0] i_Addr = '0;
  logic [31:0] o_Instr;
  logic        o_MemReady;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_gnt = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  imem_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_DataReq    (i_DataReq),
    .i_Addr       (i_Addr),
    .o_Instr      (o_Instr),
    .o_MemReady   (o_MemReady),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: multiply by an odd constant then xor, so distinct words differ.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  // Agent controls and state
  logic        gnt_rand  = 1'b0;
  logic        gnt_block = 1'b0;
  int          lat_min = 2, lat_max = 2;
  logic [31:0] rq_addr[$];
  int          rq_due[$];
  int          last_due = 0;
  int          stale_n = 0;
  int          cyc = 0;
  logic [31:0] bus_log[$];
  logic [31:0] last_gaddr = '0;
  logic        have_last = 1'b0;

  // Requester state shared with the checker
  logic [31:0] cur_addr = '0;
  logic        req_open = 1'b0;

  logic        prev_ready = 1'b0, prev_req = 1'b0, prev_gnt = 1'b0, prev_rst = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        g;
  logic        seq_ok;
  int          lat_c, due;

  // Checker and memory agent, evaluated mid-cycle.
  always @(negedge i_clk) begin
    cyc++;
    chk("bus_addr_align", {30'b0, o_mem_addr[1:0]}, 32'd0);
    chk("ready_back_to_back", {31'b0, prev_ready & o_MemReady}, 32'd0);
    if (o_MemReady) begin
      chk("ready_without_request", {31'b0, req_open}, 32'd1);
      chk("refill_word", o_Instr, mem_word(cur_addr & 32'hFFFF_FFFC));
    end
    if (i_rst && prev_rst && prev_req && !prev_gnt) begin
      chk("req_held", {31'b0, o_mem_req}, 32'd1);
      chk("req_addr_held", o_mem_addr, prev_addr);
    end

    // response for the oldest grant once its latency has elapsed
    if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = mem_word(rq_addr[0]);
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
      if (stale_n > 0) stale_n--;
    end else begin
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = $urandom;
    end

    g = o_mem_req && !gnt_block && (gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    i_mem_gnt = g;
    if (g) begin
      seq_ok = (have_last && (o_mem_addr == last_gaddr + 32'd4)) ||
               (o_mem_addr == (cur_addr & 32'hFFFF_FFFC));
      chk("grant_addr_sequence", {31'b0, seq_ok}, 32'd1);
      bus_log.push_back(o_mem_addr);
      last_gaddr = o_mem_addr;
      have_last  = 1'b1;
      lat_c = $urandom_range(lat_max, lat_min);
      due   = cyc + lat_c;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rq_addr.push_back(o_mem_addr);
      rq_due.push_back(due);
    end
    chk("outstanding_bound", {31'b0, (rq_addr.size() - stale_n) <= MAX_OUT}, 32'd1);

    if (!i_rst) begin
      have_last = 1'b0;
      stale_n   = rq_addr.size();
    end
    prev_ready = o_MemReady;
    prev_req   = o_mem_req;
    prev_addr  = o_mem_addr;
    prev_gnt   = g;
    prev_rst   = i_rst;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic start_req(input logic [31:0] a);
    i_Addr    = a;
    i_DataReq = 1'b1;
    cur_addr  = a;
    req_open  = 1'b1;
  endtask

  task automatic wait_ready(output int lat, output logic [31:0] instr);
    lat   = 0;
    instr = '0;
    for (int k = 0; k < 400; k++) begin
      @(posedge i_clk);
      #1;
      lat++;
      if (o_MemReady) begin
        instr = o_Instr;
        break;
      end
    end
    if (!o_MemReady) chk("ready_timeout", {31'b0, o_MemReady}, 32'd1);
    i_DataReq = 1'b0;
    @(posedge i_clk);
    #1;
    req_open = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] instr);
    start_req(a);
    wait_ready(lat, instr);
  endtask

  function automatic int find_addr(input logic [31:0] a);
    for (int k = 0; k < bus_log.size(); k++)
      if (bus_log[k] == a) return k;
    return -1;
  endfunction

  int          lat;
  logic [31:0] instr;
  logic [31:0] ra;
  int          idx;

  initial begin
    #2;
    chk("reset_MemReady", {31'b0, o_MemReady}, 32'd0);
    chk("reset_mem_req",  {31'b0, o_mem_req},  32'd0);
    chk("reset_mem_addr", o_mem_addr, 32'd0);
    chk("reset_Instr",    o_Instr,    32'd0);
    idle(2);
    i_rst = 1'b1;
    idle(2);

    // Cold miss and fill
    bus_log.delete();
    fetch(32'h100, lat, instr);
    chk("cold_word_0x100", instr, 32'hF778_610D);
    idle(20);
    chk("fill_grant_count", bus_log.size(), 32'd5);
    for (int k = 0; k < 5; k++) chk("fill_grant_addr", bus_log[k], 32'h100 + 32'(4 * k));
    fetch(32'h104, lat, instr);
    chk("hit_latency_0x104", lat, 32'd1);
    chk("hit_word_0x104", instr, 32'h7056_47C9);
    fetch(32'h108, lat, instr);
    chk("hit_latency_0x108", lat, 32'd1);
    idle(10);
    chk("refill_grant_count", bus_log.size(), 32'd7);
    if (bus_log.size() >= 7) chk("refill_grant_addr", bus_log[5], 32'h114);

    // Jump with responses in flight
    lat_min = 6; lat_max = 6;
    fetch(32'h200, lat, instr);
    idle(3);
    bus_log.delete();
    fetch(32'h400, lat, instr);
    chk("jump_word_0x400", instr, mem_word(32'h400));
    idx = find_addr(32'h400);
    chk("jump_grant_0x400", {31'b0, idx >= 0}, 32'd1);

    // Flush while a request is held ungranted
    lat_min = 2; lat_max = 2;
    fetch(32'h500, lat, instr);
    idle(20);
    gnt_block = 1'b1;
    fetch(32'h504, lat, instr);
    chk("hit_latency_0x504", lat, 32'd1);
    idle(2);
    chk("held_req_before_flush", {31'b0, o_mem_req}, 32'd1);
    chk("held_addr_before_flush", o_mem_addr, 32'h514);
    start_req(32'h700);
    idle(3);
    chk("held_req_after_flush", {31'b0, o_mem_req}, 32'd1);
    chk("held_addr_after_flush", o_mem_addr, 32'h514);
    gnt_block = 1'b0;
    bus_log.delete();
    wait_ready(lat, instr);
    chk("flush_word_0x700", instr, mem_word(32'h700));
    chk("stale_grant_first", bus_log.size() > 0 ? bus_log[0] : 32'hDEAD_BEEF, 32'h514);

    // Address wrap
    idle(5);
    bus_log.delete();
    fetch(32'hFFFF_FFF8, lat, instr);
    idle(20);
    chk("wrap_grant_count_min", {31'b0, bus_log.size() >= 3}, 32'd1);
    if (bus_log.size() >= 3) begin
      chk("wrap_grant0", bus_log[0], 32'hFFFF_FFF8);
      chk("wrap_grant1", bus_log[1], 32'hFFFF_FFFC);
      chk("wrap_grant2", bus_log[2], 32'h0000_0000);
    end
    fetch(32'hFFFF_FFFC, lat, instr);
    chk("wrap_hit_latency_fffc", lat, 32'd1);
    fetch(32'h0, lat, instr);
    chk("wrap_hit_latency_0", lat, 32'd1);

    // Async reset with two reads outstanding
    idle(20);
    lat_min = 6; lat_max = 6;
    start_req(32'h300);
    for (int k = 0; k < 60 && rq_addr.size() < 2; k++) idle(1);
    chk("two_outstanding_before_reset", {31'b0, rq_addr.size() >= 2}, 32'd1);
    #2;
    i_rst = 1'b0;
    #1;
    chk("async_rst_MemReady", {31'b0, o_MemReady}, 32'd0);
    chk("async_rst_mem_req",  {31'b0, o_mem_req},  32'd0);
    chk("async_rst_mem_addr", o_mem_addr, 32'd0);
    chk("async_rst_Instr",    o_Instr,    32'd0);
    i_DataReq = 1'b0;
    req_open  = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    idle(12);
    bus_log.delete();
    fetch(32'h0, lat, instr);
    chk("post_reset_word_0", instr, 32'hC001_D00D);
    chk("post_reset_fresh_read", bus_log.size() > 0 ? bus_log[0] : 32'hDEAD_BEEF, 32'h0);

    // Randomized traffic
    gnt_rand = 1'b1;
    lat_min  = 1;
    lat_max  = 5;
    ra = 32'h1000;
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    ra = {$urandom_range(0, 1023), 2'b00} << 2;
        2:       ra = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
        3:       ra = ra;
        default: ra = ra + 32'd4;
      endcase
      fetch(ra | 32'($urandom_range(0, 3)), lat, instr);
      chk("rand_word", instr, mem_word(ra & 32'hFFFF_FFFC));
      ra = ra & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) idle($urandom_range(5, 15));
      else idle($urandom_range(0, 3));
    end

    idle(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
